// File: rtl/mem_access_unit.sv
// MEM stage of the rvseed pipeline: issues one load/store per instruction on a
// req/gnt/rvalid bus, aligns store data, extends load data and registers write-back.
module mem_access_unit #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_reg_wen,
  input  logic [RADDR_W-1:0] in_reg_waddr,
  input  logic [XLEN-1:0]    in_alu_res,
  input  logic [XLEN-1:0]    in_st_data,
  input  logic               in_st_flag,
  input  logic [7:0]         in_wmask,
  input  logic [2:0]         in_ld_type,
  input  logic               in_ebreak,
  input  logic [XLEN-1:0]    in_pc,
  output logic               mem_stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [7:0]         mem_wstrb,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               wb_valid,
  output logic               wb_wen,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic               wb_ebreak,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  state_t state_q, state_d;

  // Instruction fields captured when a bus access starts
  logic               lat_wen;
  logic [RADDR_W-1:0] lat_waddr;
  logic [XLEN-1:0]    lat_res;
  logic               lat_st;
  logic [2:0]         lat_ld_type;
  logic               lat_ebreak;
  logic [XLEN-1:0]    lat_pc;
  logic [XLEN-1:0]    lat_wdata;
  logic [7:0]         lat_wstrb;

  logic     is_mem;
  logic     misaligned;
  logic     mis_mem;
  logic     start_mem;
  logic     retire_direct;
  logic     retire_mem;
  size_t    acc_size;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] load_val;

  assign is_mem        = in_st_flag | (in_ld_type != 3'd0);
  assign mis_mem       = is_mem & misaligned;
  assign start_mem     = (state_q == IDLE) & in_valid & is_mem & ~misaligned;
  assign retire_direct = (state_q == IDLE) & in_valid & ~(is_mem & ~misaligned);
  assign retire_mem    = (state_q == WAIT) & mem_rvalid;

  // Access size: popcount of the mask for stores, load type for loads
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_size   = SZ_B;
    misaligned = 1'b0;
    if (in_st_flag) begin
      case ($countones(in_wmask))
        2:       acc_size = SZ_H;
        4:       acc_size = SZ_W;
        8:       acc_size = SZ_D;
        default: acc_size = SZ_B;
      endcase
    end else begin
      case (in_ld_type)
        3'd2, 3'd6: acc_size = SZ_H;
        3'd3, 3'd7: acc_size = SZ_W;
        3'd4:       acc_size = SZ_D;
        default:    acc_size = SZ_B;
      endcase
    end
    case (acc_size)
      SZ_H:    misaligned = in_alu_res[0];
      SZ_W:    misaligned = |in_alu_res[1:0];
      SZ_D:    misaligned = |in_alu_res[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Load data: pick the lane at the latched byte offset, then extend
  assign rd_shifted = mem_rdata >> {lat_res[2:0], 3'b000};

  always_comb begin
    load_val = rd_shifted;
    case (lat_ld_type)
      3'd1:    load_val = {{(XLEN-8){rd_shifted[7]}},   rd_shifted[7:0]};
      3'd2:    load_val = {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'd3:    load_val = {{(XLEN-32){rd_shifted[31]}}, rd_shifted[31:0]};
      3'd5:    load_val = {{(XLEN-8){1'b0}},  rd_shifted[7:0]};
      3'd6:    load_val = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      3'd7:    load_val = {{(XLEN-32){1'b0}}, rd_shifted[31:0]};
      default: load_val = rd_shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_stall = start_mem;
    case (state_q)
      IDLE: if (start_mem) state_d = REQ;
      REQ: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        // Stall drops in the rvalid cycle so upstream advances as wb_* loads
        mem_stall = ~mem_rvalid;
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is reset explicitly because the bus outputs
    // are driven straight from them and must read 0 out of reset.
    if (!rst_n) begin
      lat_wen     <= 1'b0;
      lat_waddr   <= '0;
      lat_res     <= '0;
      lat_st      <= 1'b0;
      lat_ld_type <= 3'd0;
      lat_ebreak  <= 1'b0;
      lat_pc      <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= 8'h00;
    end else if (start_mem) begin
      lat_wen     <= in_reg_wen;
      lat_waddr   <= in_reg_waddr;
      lat_res     <= in_alu_res;
      lat_st      <= in_st_flag;
      lat_ld_type <= in_ld_type;
      lat_ebreak  <= in_ebreak;
      lat_pc      <= in_pc;
      lat_wdata   <= in_st_data << {in_alu_res[2:0], 3'b000};
      lat_wstrb   <= in_wmask << in_alu_res[2:0];
    end
  end

  assign mem_we    = lat_st;
  assign mem_addr  = {lat_res[XLEN-1:3], 3'b000};
  assign mem_wdata = lat_wdata;
  assign mem_wstrb = lat_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_wen      <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_ebreak   <= 1'b0;
      wb_pc       <= XLEN'(64'h8000_0000);
      wb_misalign <= 1'b0;
    end else begin
      wb_valid <= retire_direct | retire_mem;
      if (retire_direct) begin
        wb_wen      <= in_reg_wen & ~mis_mem;
        wb_waddr    <= in_reg_waddr;
        wb_wdata    <= in_alu_res;
        wb_ebreak   <= in_ebreak;
        wb_pc       <= in_pc;
        wb_misalign <= mis_mem;
      end else if (retire_mem) begin
        wb_wen      <= lat_wen;
        wb_waddr    <= lat_waddr;
        wb_wdata    <= lat_st ? lat_res : load_val;
        wb_ebreak   <= lat_ebreak;
        wb_pc       <= lat_pc;
        wb_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// instructions checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_reg_wen;
  logic [4:0]  in_reg_waddr;
  logic [63:0] in_alu_res;
  logic [63:0] in_st_data;
  logic        in_st_flag;
  logic [7:0]  in_wmask;
  logic [2:0]  in_ld_type;
  logic        in_ebreak;
  logic [63:0] in_pc;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        wb_ebreak;
  logic [63:0] wb_pc;
  logic        wb_misalign;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_wen(in_reg_wen),
    .in_reg_waddr(in_reg_waddr), .in_alu_res(in_alu_res), .in_st_data(in_st_data),
    .in_st_flag(in_st_flag), .in_wmask(in_wmask), .in_ld_type(in_ld_type),
    .in_ebreak(in_ebreak), .in_pc(in_pc), .mem_stall(mem_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_ebreak(wb_ebreak), .wb_pc(wb_pc), .wb_misalign(wb_misalign)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the instruction's own fields
  function automatic int size_of(input logic st, input logic [7:0] wm, input logic [2:0] ld);
    if (st) return $countones(wm);
    case (ld)
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] ld, input int off,
                                             input logic [63:0] word);
    int          sz = size_of(1'b0, 8'h00, ld);
    logic [63:0] v  = word >> (8 * off);
    logic [63:0] keep;
    if (sz < 8) begin
      keep = (64'd1 << (8 * sz)) - 64'd1;
      v = v & keep;
      if (ld <= 3'd3 && v[8*sz-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // Issues one instruction from a post-edge point and returns at one as well
  task automatic run_op(input logic wen, input logic [4:0] rd, input logic [63:0] res,
                        input logic [63:0] sdata, input logic st, input logic [7:0] wm,
                        input logic [2:0] ld, input logic eb, input logic [63:0] pc,
                        input logic [63:0] rdata, input int gnt_dly, input int rv_dly);
    logic is_mem = st | (ld != 3'd0);
    int   off    = int'(res[2:0]);
    logic mis    = is_mem && ((off % size_of(st, wm, ld)) != 0);
    logic [63:0] exp_wd;
    in_reg_wen = wen; in_reg_waddr = rd; in_alu_res = res; in_st_data = sdata;
    in_st_flag = st; in_wmask = wm; in_ld_type = ld; in_ebreak = eb; in_pc = pc;
    in_valid = 1'b1;
    if (!is_mem || mis) begin
      @(negedge clk);
      chk("direct_stall", {63'd0, mem_stall}, 64'd0);
      chk("direct_req", {63'd0, mem_req}, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("direct_wb_valid", {63'd0, wb_valid}, 64'd1);
      chk("direct_wb_wdata", wb_wdata, res);
      chk("direct_wb_wen", {63'd0, wb_wen}, {63'd0, wen & ~mis});
      chk("direct_wb_misalign", {63'd0, wb_misalign}, {63'd0, mis});
      chk("direct_wb_meta", {wb_pc[57:0], wb_waddr, wb_ebreak}, {pc[57:0], rd, eb});
    end else begin
      @(negedge clk);
      chk("idle_stall", {63'd0, mem_stall}, 64'd1);
      @(posedge clk); #1;
      for (int i = 0; i <= gnt_dly; i++) begin
        if (i == gnt_dly) mem_gnt = 1'b1;
        @(negedge clk);
        chk("req_req", {63'd0, mem_req}, 64'd1);
        chk("req_stall", {63'd0, mem_stall}, 64'd1);
        chk("req_addr", mem_addr, {res[63:3], 3'b000});
        chk("req_we", {63'd0, mem_we}, {63'd0, st});
        if (st) begin
          chk("req_wdata", mem_wdata, sdata << (8 * off));
          chk("req_wstrb", {56'd0, mem_wstrb}, {56'd0, 8'(wm << off)});
        end
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0;
      for (int i = 1; i < rv_dly; i++) begin
        @(negedge clk);
        chk("wait_req", {63'd0, mem_req}, 64'd0);
        chk("wait_stall", {63'd0, mem_stall}, 64'd1);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      chk("rvalid_stall", {63'd0, mem_stall}, 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; in_valid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      exp_wd = st ? res : model_load(ld, off, rdata);
      chk("mem_wb_valid", {63'd0, wb_valid}, 64'd1);
      chk("mem_wb_wdata", wb_wdata, exp_wd);
      chk("mem_wb_wen", {63'd0, wb_wen}, {63'd0, wen});
      chk("mem_wb_misalign", {63'd0, wb_misalign}, 64'd0);
      chk("mem_wb_meta", {wb_pc[57:0], wb_waddr, wb_ebreak}, {pc[57:0], rd, eb});
    end
    @(posedge clk); #1;
    chk("wb_valid_pulse", {63'd0, wb_valid}, 64'd0);
  endtask

  initial begin
    logic [7:0]  masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    int          kind;
    logic [2:0]  ld;
    logic        st;
    logic [7:0]  wm;

    rst_n = 1'b0; in_valid = 1'b0; in_reg_wen = 1'b0; in_reg_waddr = '0;
    in_alu_res = '0; in_st_data = '0; in_st_flag = 1'b0; in_wmask = '0;
    in_ld_type = '0; in_ebreak = 1'b0; in_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_stall_valid", {61'd0, mem_req, mem_stall, wb_valid}, 64'd0);
    chk("reset_wb_pc", wb_pc, 64'h8000_0000);
    chk("reset_wb_wdata", wb_wdata, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD
    run_op(1'b1, 5'd5, 64'h1234, 64'd0, 1'b0, 8'h00, 3'd0, 1'b0, 64'h8000_0010,
           64'd0, 0, 1);
    // LB, sign bit set in byte 3
    run_op(1'b1, 5'd6, 64'h8000_0003, 64'd0, 1'b0, 8'h00, 3'd1, 1'b0, 64'h8000_0014,
           64'h0000_0000_8000_0000, 2, 3);
    chk("lb_const", wb_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    // LHU from the top half
    run_op(1'b1, 5'd7, 64'h8000_0106, 64'd0, 1'b0, 8'h00, 3'd6, 1'b0, 64'h8000_0018,
           64'hBEEF_1234_5678_9ABC, 0, 1);
    chk("lhu_const", wb_wdata, 64'h0000_0000_0000_BEEF);
    // SW into the upper word
    run_op(1'b0, 5'd0, 64'h8000_0204, 64'hDEAD_BEEF, 1'b1, 8'h0F, 3'd0, 1'b0,
           64'h8000_001C, 64'd0, 1, 2);
    // Misaligned LW
    run_op(1'b1, 5'd8, 64'h8000_0302, 64'd0, 1'b0, 8'h00, 3'd3, 1'b1, 64'h8000_0020,
           64'd0, 0, 1);

    // Reset while a load waits for rvalid
    in_reg_wen = 1'b1; in_reg_waddr = 5'd9; in_alu_res = 64'h8000_0400;
    in_st_flag = 1'b0; in_wmask = 8'h00; in_ld_type = 3'd4; in_pc = 64'h8000_0024;
    in_valid = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("pre_reset_wait_stall", {62'd0, mem_req, mem_stall}, 64'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_reset_req_stall_valid", {61'd0, mem_req, mem_stall, wb_valid}, 64'd0);
    chk("async_reset_wb_pc", wb_pc, 64'h8000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("stray_rvalid_ignored", {62'd0, wb_valid, mem_stall}, 64'd0);
    run_op(1'b1, 5'd10, 64'h8000_0408, 64'd0, 1'b0, 8'h00, 3'd4, 1'b0, 64'h8000_0028,
           64'h0123_4567_89AB_CDEF, 1, 1);

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      st = (kind == 2);
      ld = (kind == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      wm = st ? masks[$urandom_range(0, 3)] : 8'h00;
      run_op(1'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             st, wm, ld, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
